// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: bus structs, FSM states,
// address-split width helpers and per-line metadata.
package icache_pkg;

  localparam int ICACHE_ADDR_W    = 64;
  // Widest tag possible with SETS>=2 and LINE_WORDS>=2; narrower tags are zero-extended.
  localparam int ICACHE_TAG_MAX_W = 60;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESP
  } icache_state_t;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int OFFSET_W(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int INDEX_W(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int ICACHE_TAG_W(input int sets, input int line_words);
    return ICACHE_ADDR_W - 2 - INDEX_W(sets) - OFFSET_W(line_words);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Line storage: SETS x LINE_WORDS 32-bit words, one synchronous write port and
// one combinational read port. Contents are not reset; validity lives in the top.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            i_we,
  input  logic [INDEX_W(SETS)-1:0]        i_w_index,
  input  logic [OFFSET_W(LINE_WORDS)-1:0] i_w_word,
  input  logic [31:0]                     i_w_data,
  input  logic [INDEX_W(SETS)-1:0]        i_r_index,
  input  logic [OFFSET_W(LINE_WORDS)-1:0] i_r_word,
  output logic [31:0]                     o_r_data
);

  logic [31:0] r_mem [SETS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[{i_w_index, i_w_word}] <= i_w_data;
  end

  assign o_r_data = r_mem[{i_r_index, i_r_word}];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only I-cache: hits answer one cycle after the request, misses
// refill a whole line as sequential word reads. ICACHE_PERF_CNT_EN adds hit/miss counters.
module icache_direct
  import icache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  output ibus_req_t   mreq,
  input  ibus_resp_t  mresp
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [63:0] hit_cnt,
  output logic [63:0] miss_cnt
`endif
);

  localparam int OW = OFFSET_W(LINE_WORDS);
  localparam int IW = INDEX_W(SETS);
  localparam int TW = ICACHE_TAG_W(SETS, LINE_WORDS);
  localparam logic [OW-1:0] BEAT_LAST = OW'(LINE_WORDS - 1);

  icache_state_t r_state, w_state_nxt;
  logic [OW-1:0] r_beat;
  logic [63:0]   r_addr;
  logic [31:0]   r_word;
  line_meta_t    r_meta [SETS];

  logic [IW-1:0] w_req_idx, w_lat_idx, w_rd_idx;
  logic [OW-1:0] w_req_off, w_lat_off, w_rd_off;
  logic [TW-1:0] w_req_tag, w_lat_tag;
  logic          w_hit, w_arr_we, w_fill_done, w_take_hit, w_take_miss;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  assign w_req_off = ireq.addr[2 +: OW];
  assign w_req_idx = ireq.addr[2+OW +: IW];
  assign w_req_tag = ireq.addr[63 -: TW];
  assign w_lat_off = r_addr[2 +: OW];
  assign w_lat_idx = r_addr[2+OW +: IW];
  assign w_lat_tag = r_addr[63 -: TW];
  assign w_unused  = ^{ireq.addr[1:0], r_addr[1:0], mresp.addr_ok};

  assign w_hit = r_meta[w_req_idx].valid &&
                 (r_meta[w_req_idx].tag == ICACHE_TAG_MAX_W'(w_req_tag));

  assign w_take_hit  = (r_state == S_IDLE) && ireq.valid && w_hit;
  assign w_take_miss = (r_state == S_IDLE) && ireq.valid && !w_hit;

  // During refill the read port looks at the latched line so the final word can be picked.
  assign w_rd_idx = (r_state == S_REFILL) ? w_lat_idx : w_req_idx;
  assign w_rd_off = (r_state == S_REFILL) ? w_lat_off : w_req_off;

  icache_data_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_data (
    .clk       (clk),
    .i_we      (w_arr_we),
    .i_w_index (w_lat_idx),
    .i_w_word  (r_beat),
    .i_w_data  (mresp.data),
    .i_r_index (w_rd_idx),
    .i_r_word  (w_rd_off),
    .o_r_data  (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    iresp       = '0;
    mreq        = '0;
    w_arr_we    = 1'b0;
    w_fill_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ireq.valid) w_state_nxt = w_hit ? S_RESP : S_REFILL;
      end
      S_REFILL: begin
        mreq.valid = 1'b1;
        mreq.addr  = {r_addr[63:2+OW], r_beat, 2'b00};
        if (mresp.data_ok) begin
          w_arr_we = 1'b1;
          if (r_beat == BEAT_LAST) begin
            w_fill_done = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = r_word;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      for (int s = 0; s < SETS; s++) r_meta[s] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_hit) r_word <= w_rd_data;
      if (w_take_miss) begin
        r_addr <= ireq.addr;
        r_beat <= '0;
      end
      if (w_arr_we) r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
      if (w_fill_done) begin
        r_meta[w_lat_idx] <= '{valid: 1'b1, tag: ICACHE_TAG_MAX_W'(w_lat_tag)};
        // The last beat is not in the array yet, so forward it when it is the wanted word.
        r_word <= (w_lat_off == BEAT_LAST) ? mresp.data : w_rd_data;
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [63:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_take_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 64'd1;
      if (w_take_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 64'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct with a stall-configurable word memory model.
module tb_icache_direct;
  import icache_pkg::*;

  logic       clk;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  ibus_req_t  mreq;
  ibus_resp_t mresp;
`ifdef ICACHE_PERF_CNT_EN
  logic [63:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int stall  = 0;
  int mcnt;
  logic inj_dok = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  icache_direct #(.SETS(16), .LINE_WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ireq     (ireq),
    .iresp    (iresp),
    .mreq     (mreq),
    .mresp    (mresp)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Memory answers each beat after 'stall' extra cycles of holding the same address.
  always @(posedge clk or posedge rst) begin
    if (rst) mcnt <= 0;
    else if (!mreq.valid || mresp.data_ok) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  always_comb begin
    mresp = '0;
    if (mreq.valid && (mcnt == stall)) begin
      mresp.addr_ok = 1'b1;
      mresp.data_ok = 1'b1;
      mresp.data    = memf(mreq.addr);
    end
    if (inj_dok) begin
      mresp.data_ok = 1'b1;
      mresp.data    = 32'hDEAD_BEEF;
    end
  end

  task automatic do_read(input logic [63:0] a, input int exp_lat, input int exp_beats,
                         input string tag);
    logic [63:0] base;
    int  n, k;
    bit  done;
    base = {a[63:4], 4'h0};
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    n = 0; k = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (mreq.valid) begin
        chk({tag, "/mreq_addr"}, mreq.addr, base + 64'(4 * k));
        if (mresp.data_ok) k++;
      end
      if (iresp.data_ok) done = 1'b1;
    end
    chk({tag, "/responded"}, 64'(done), 64'd1);
    chk({tag, "/latency"}, 64'(n + 1), 64'(exp_lat));
    chk({tag, "/beats"}, 64'(k), 64'(exp_beats));
    chk({tag, "/data"}, 64'(iresp.data), 64'(memf(a)));
    chk({tag, "/addr_ok"}, 64'(iresp.addr_ok), 64'd1);
    ireq.valid = 1'b0;
    @(negedge clk);
    chk({tag, "/one_pulse"}, 64'(iresp.data_ok), 64'd0);
    chk({tag, "/mreq_idle"}, 64'(mreq.valid), 64'd0);
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    ireq = '0;
    repeat (2) @(negedge clk);
    chk("reset/iresp", 64'(iresp), 64'h0);
    chk("reset/mreq_valid", 64'(mreq.valid), 64'd0);
    chk("reset/mreq_addr", mreq.addr, 64'h0);
`ifdef ICACHE_PERF_CNT_EN
    chk("reset/hit_cnt", hit_cnt, 64'h0);
    chk("reset/miss_cnt", miss_cnt, 64'h0);
`endif
    rst = 1'b0;

    do_read(64'h8000_0004, 6, 4, "cold_miss");
    do_read(64'h8000_0008, 2, 0, "hit_after_fill");
    do_read(64'h8000_0100, 6, 4, "conflict_fill");
    do_read(64'h8000_0000, 6, 4, "conflict_refetch");

    stall = 3;
    do_read(64'h8000_004C, 18, 4, "stall_miss_last_word");
    do_read(64'h8000_0040, 2, 0, "stall_hit");
    stall = 0;

    // Reset in the beat-2 cycle of a refill.
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0200;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mreq.valid && mreq.addr == 64'h8000_0208) && n < 50);
    chk("rst_mid/reached_beat2", mreq.addr, 64'h8000_0208);
    rst = 1'b1;
    #1;
    chk("rst_mid/mreq_valid", 64'(mreq.valid), 64'd0);
    chk("rst_mid/mreq_addr", mreq.addr, 64'h0);
    chk("rst_mid/iresp", 64'(iresp), 64'h0);
    ireq.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inj_dok = 1'b1;
    @(negedge clk);
    inj_dok = 1'b0;
    chk("rst_mid/late_dok_ignored", 64'({iresp.data_ok, mreq.valid}), 64'd0);
    @(negedge clk);
    chk("rst_mid/still_idle", 64'({iresp.data_ok, mreq.valid}), 64'd0);

    do_read(64'h8000_0200, 6, 4, "after_rst_refill");
    do_read(64'h8000_0204, 2, 0, "after_rst_hit1");
    do_read(64'h8000_0208, 2, 0, "after_rst_hit2");
    do_read(64'h8000_020C, 2, 0, "after_rst_hit3");
`ifdef ICACHE_PERF_CNT_EN
    chk("perf/miss_cnt", miss_cnt, 64'd1);
    chk("perf/hit_cnt", hit_cnt, 64'd3);
`endif
    do_read(64'h8000_0040, 6, 4, "after_rst_valid_cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
